// File: rtl/bus_pipe_master_if.sv
// Request/response stream plus Wishbone B4 bus signals of the pipelined master.
// The master modport is the engine side; slave is the core + interconnect side.
interface bus_pipe_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] addr;
    logic [31:0] data_m2s;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic [31:0] data_s2m;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        input  req_valid, req_addr, req_we, req_sel, req_wdata, data_s2m, ack, err, stall,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_m2s, we, sel, cyc, stb
    );
    modport slave (
        output req_valid, req_addr, req_we, req_sel, req_wdata, data_s2m, ack, err, stall,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_m2s, we, sel, cyc, stb
    );
endinterface

// File: rtl/bus_pipe_master.sv
// Pipelined Wishbone B4 master: valid/ready requests become bus transfers, with
// one in-order response per request; err or a response timeout aborts the cycle.
module bus_pipe_master #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input logic               clk,
    input logic               rst,
    bus_pipe_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [15:0] timer;
    logic [4:0]  pending;

    logic        accept, issue, resp, timeout, stb_next;
    logic [4:0]  inflight;
    logic [3:0]  count_next;

    always_comb begin
        inflight      = {1'b0, count} + {4'b0, bus.stb};
        bus.req_ready = (state != ABORT) && !(bus.stb && bus.stall) &&
                        (inflight < 5'(MAX_OUTSTANDING)) &&
                        ((count == 4'd0 && !bus.stb) || (bus.req_we == bus.we));
        accept     = bus.req_valid && bus.req_ready;
        issue      = (state == ACTIVE) && bus.stb && !bus.stall;
        // A stray ack/err with nothing on the bus is dropped.
        resp       = (state == ACTIVE) && (bus.ack || bus.err) && (count != 4'd0 || issue);
        count_next = count + {3'b0, issue} - {3'b0, resp};
        stb_next   = accept || (bus.stb && !issue);
        timeout    = (state == ACTIVE) && !resp && !issue && (count != 4'd0) &&
                     (timer == 16'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            timer         <= '0;
            pending       <= '0;
            bus.cyc       <= 1'b0;
            bus.stb       <= 1'b0;
            bus.we        <= 1'b0;
            bus.addr      <= '0;
            bus.data_m2s  <= '0;
            bus.sel       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            if (accept) begin
                bus.addr     <= bus.req_addr;
                bus.data_m2s <= bus.req_wdata;
                bus.we       <= bus.req_we;
                bus.sel      <= bus.req_sel;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= ACTIVE;
                        bus.cyc <= 1'b1;
                        bus.stb <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (resp) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= (bus.err || bus.we) ? 32'h0 : bus.data_s2m;
                        bus.rsp_err   <= bus.err;
                    end
                    // pending also covers a transfer on stb and one accepted this edge,
                    // so every accepted request still gets exactly one response.
                    if (resp && bus.err) begin
                        state   <= ABORT;
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                        count   <= '0;
                        timer   <= '0;
                        pending <= {1'b0, count} - 5'd1 + {4'b0, bus.stb} + {4'b0, accept};
                    end else if (timeout) begin
                        state   <= ABORT;
                        bus.cyc <= 1'b0;
                        bus.stb <= 1'b0;
                        count   <= '0;
                        timer   <= '0;
                        pending <= {1'b0, count} + {4'b0, bus.stb} + {4'b0, accept};
                    end else begin
                        count   <= count_next;
                        bus.stb <= stb_next;
                        if (resp || issue || count == 4'd0) timer <= '0;
                        else                                timer <= timer + 16'd1;
                        if (count_next == 4'd0 && !stb_next) begin
                            state   <= IDLE;
                            bus.cyc <= 1'b0;
                        end
                    end
                end
                ABORT: begin
                    if (pending != 5'd0) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        pending       <= pending - 5'd1;
                        if (pending == 5'd1) state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_pipe_master.sv
// Scoreboard bench: a behavioural Wishbone slave serves the bus while a
// sequential memory model predicts every response in request order.
module tb_bus_pipe_master;
    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bus_pipe_master_if bus();
    bus_pipe_master #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];
    int   rsp_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every response strobe pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid) begin
            rsp_total++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata %h err %b, expected no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    logic cyc_q = 1'b0;
    int   cyc_falls = 0;
    always @(negedge clk) begin
        if (cyc_q && !bus.cyc) cyc_falls++;
        cyc_q = bus.cyc;
    end

    // Behavioural slave: decides stall/ack for the coming edge, in-order acks.
    typedef struct { int unsigned due; logic [31:0] data; logic e; } sack_t;
    logic [31:0] smem    [8];
    logic [31:0] ref_mem [8];
    sack_t       sq[$];
    int          lat_min = 1, lat_max = 1, stall_pct = 0, silent = 0;
    int          err_idx = -1, stall_idx = -1, stall_len = 0, issue_cnt = 0;
    int unsigned last_issue = 0, last_due = 0;

    always @(negedge clk) begin
        sack_t       s;
        logic [2:0]  ix;
        int unsigned due;
        bus.ack      = 1'b0;
        bus.err      = 1'b0;
        bus.data_s2m = $urandom;
        bus.stall    = 1'b0;
        if (rst || !bus.cyc) begin
            sq.delete();
        end else begin
            if (bus.stb && issue_cnt == stall_idx && stall_len > 0) begin
                bus.stall = 1'b1;
                stall_len--;
            end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                bus.stall = 1'b1;
            end
            if (sq.size() > 0 && sq[0].due <= edge_n + 1) begin
                s = sq.pop_front();
                bus.ack      = !s.e;
                bus.err      = s.e;
                bus.data_s2m = s.data;
            end
            if (bus.stb && !bus.stall) begin
                ix     = bus.addr[4:2];
                s.data = bus.we ? $urandom : smem[ix];
                if (bus.we)
                    for (int b = 0; b < 4; b++)
                        if (bus.sel[b]) smem[ix][8*b +: 8] = bus.data_m2s[8*b +: 8];
                s.e = (issue_cnt == err_idx);
                due = edge_n + 1 + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                s.due      = due;
                last_due   = due;
                last_issue = edge_n + 1;
                issue_cnt++;
                if (silent == 0) sq.push_back(s);
            end
        end
    end

    logic exp_err_mode = 1'b0;

    task automatic tick();
        @(negedge clk);
        #1 bus.req_valid = 1'b0;
        #1;
    endtask

    // Present one request until accepted; the reference model is updated at acceptance.
    task automatic send(input logic w, input logic [2:0] ix, input logic [31:0] d,
                        input logic [3:0] sl, output int waited);
        exp_t e;
        waited = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.req_we    = w;
            bus.req_addr  = 32'h1000_0000 | {27'b0, ix, 2'b00};
            bus.req_wdata = d;
            bus.req_sel   = sl;
            #1;
            if (bus.req_ready) begin
                e.err   = exp_err_mode;
                e.rdata = 32'h0;
                if (!exp_err_mode) begin
                    if (w) begin
                        for (int b = 0; b < 4; b++)
                            if (sl[b]) ref_mem[ix][8*b +: 8] = d[8*b +: 8];
                    end else begin
                        e.rdata = ref_mem[ix];
                    end
                end
                exp_q.push_back(e);
                return;
            end
            waited++;
        end
        checks++;
        errors++;
        $display("FAIL send_accept: request not accepted after %0d cycles, expected acceptance", waited);
    endtask

    task automatic wait_rsp(input int target, input string name);
        int k;
        k = 0;
        while (rsp_total < target && k < 60) begin
            tick();
            k++;
        end
        chk(name, 32'(rsp_total >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
    endtask

    int w, base, falls0, stall_seen, stall_bad, blocked;
    logic wdir;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_sel   = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            smem[i]    = $urandom;
            ref_mem[i] = smem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_stb", 32'(bus.stb), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_data_m2s", bus.data_m2s, 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Single read, ack one cycle after stb
        smem[1] = 32'hDEAD_BEEF;
        ref_mem[1] = 32'hDEAD_BEEF;
        base = rsp_total;
        send(1'b0, 3'd1, 32'h0, 4'hF, w);
        tick();
        chk("rd_stb", 32'(bus.stb), 32'd1);
        chk("rd_addr", bus.addr, 32'h1000_0004);
        wait_rsp(base + 1, "rd_rsp_seen");
        chk("rd_cyc_after_ack", 32'(bus.cyc), 32'd0);
        drain("rd_drain");
        chk("rd_one_rsp", 32'(rsp_total - base), 32'd1);

        // Burst of 6 writes, 3-cycle ack latency
        lat_min = 3; lat_max = 3;
        base = rsp_total; falls0 = cyc_falls; blocked = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 3'(i), $urandom, 4'($urandom_range(15, 1)), w);
            if (w > 0) blocked++;
        end
        drain("burst_drain");
        chk("burst_ready_fell", 32'(blocked > 0), 32'd1);
        chk("burst_rsp_count", 32'(rsp_total - base), 32'd6);
        chk("burst_cyc_continuous", 32'(cyc_falls - falls0), 32'd1);

        // Stall 5 cycles on the 2nd read
        lat_min = 1; lat_max = 1;
        stall_idx = issue_cnt + 1; stall_len = 5;
        send(1'b0, 3'd2, 32'h0, 4'hF, w);
        send(1'b0, 3'd3, 32'h0, 4'hF, w);
        stall_seen = 0; stall_bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.stall) begin
                stall_seen++;
                if (!bus.stb || bus.addr != 32'h1000_000C) stall_bad++;
            end
        end
        stall_idx = -1;
        chk("stall_cycles", 32'(stall_seen), 32'd5);
        chk("stall_stb_addr_hold", 32'(stall_bad), 32'd0);
        drain("stall_drain");

        // Read immediately followed by a write
        base = rsp_total;
        send(1'b0, 3'd4, 32'h0, 4'hF, w);
        send(1'b1, 3'd5, $urandom, 4'hF, w);
        chk("rw_write_waited", 32'(w >= 1), 32'd1);
        chk("rw_read_done_first", 32'(rsp_total - base), 32'd1);
        drain("rw_drain");

        // err on the first of 3 outstanding reads
        lat_min = 3; lat_max = 3;
        err_idx = issue_cnt;
        exp_err_mode = 1'b1;
        base = rsp_total;
        for (int i = 0; i < 3; i++) send(1'b0, 3'(i), 32'h0, 4'hF, w);
        exp_err_mode = 1'b0;
        wait_rsp(base + 1, "err_first_rsp");
        chk("err_cyc_drop", 32'(bus.cyc), 32'd0);
        tick();
        chk("err_flush1", 32'(bus.rsp_valid && bus.rsp_err), 32'd1);
        tick();
        chk("err_flush2", 32'(bus.rsp_valid && bus.rsp_err), 32'd1);
        tick();
        chk("err_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
        err_idx = -1;
        drain("err_drain");

        // Silent slave: timeout after TMO cycles
        silent = 1; lat_min = 1; lat_max = 1;
        exp_err_mode = 1'b1;
        base = rsp_total;
        send(1'b0, 3'd6, 32'h0, 4'hF, w);
        send(1'b0, 3'd7, 32'h0, 4'hF, w);
        exp_err_mode = 1'b0;
        for (int k = 0; k < 40 && bus.cyc; k++) tick();
        chk("tmo_cycles", edge_n - last_issue, 32'(TMO));
        wait_rsp(base + 2, "tmo_rsp_seen");
        silent = 0;
        drain("tmo_drain");

        // Asynchronous reset mid-burst
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) send(1'b0, 3'(i), 32'h0, 4'hF, w);
        tick();
        chk("pre_rst_cyc", 32'(bus.cyc), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_bus", {bus.addr[29:0], bus.cyc, bus.stb}, 32'd0);
        chk("async_rst_misc", {22'd0, bus.sel, bus.we, bus.rsp_valid, bus.rsp_err, bus.data_m2s[2:0]}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        chk("post_rst_ready", {30'd0, bus.cyc, bus.req_ready}, 32'd1);

        // Randomized mixed traffic
        lat_min = 1; lat_max = 3; stall_pct = 20;
        wdir = 1'b0;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(3) == 0) wdir = ~wdir;
            if ($urandom_range(4) == 0) tick();
            send(wdir, 3'($urandom_range(7)), $urandom, 4'($urandom_range(15, 1)), w);
        end
        stall_pct = 0;
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_pipe_master.md
# bus_pipe_master

Pipelined Wishbone B4 master engine. It converts a simple valid/ready request stream from a CPU core or DMA into bus cycles on a `bus_master_if`-style port and returns one response per request in issue order. It tracks up to `MAX_OUTSTANDING` in-flight transfers, honours `stall`, and aborts the cycle on `err` or on a response timeout. It sits between the core's load/store unit and the system interconnect, opposite the slaves that decode `cyc`/`stb`.

## Interface
- `MAX_OUTSTANDING`, 4: maximum issued-but-unacknowledged transfers (1..15).
- `TIMEOUT`, 255: cycles without `ack`/`err` while transfers are outstanding before abort (1..65535).
- `clk` in 1: bus clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1 = write.
- `req_sel` in 4: byte lanes.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle response strobe; no backpressure.
- `rsp_rdata` out 32: read data (0 for writes and errors).
- `rsp_err` out 1: bus error or aborted/timed-out transfer.
- `addr` out 32, `data_m2s` out 32, `we` out 1, `sel` out 4, `cyc` out 1, `stb` out 1: Wishbone master outputs, all registered.
- `data_s2m` in 32, `ack` in 1, `err` in 1, `stall` in 1: Wishbone slave returns.

## Operation
- State machine with three states:
  - IDLE: `cyc` = 0, outstanding count = 0.
  - ACTIVE: `cyc` = 1; issuing transfers and/or waiting for responses.
  - ABORT: `cyc` = 0; flushing error responses.
- `req_ready` is 1 only when all of the following hold:
  - state is not ABORT;
  - not (`stb && stall`);
  - `count + stb < MAX_OUTSTANDING`;
  - either the bus is empty (`count == 0 && !stb`) or `req_we == we`.
- Reads and writes are never mixed inside one direction run. A request of the other direction waits until all outstanding transfers drain. `cyc` may stay high across the switch.
- When a request is accepted:
  - `addr`, `data_m2s`, `we`, `sel` load from the request;
  - `stb` and `cyc` become 1 on the next edge;
  - state moves IDLE→ACTIVE.
- Issue occurs in any cycle with `stb && !stall`. `stb` then drops unless a new request is accepted in the same cycle. While `stall` is high, `stb` and all address/data outputs hold.
- `count` (4 bits) rules:
  - +1 on issue, −1 on `ack|err`;
  - both in the same cycle leaves `count` unchanged;
  - `ack`/`err` with `count == 0` and no issue in that cycle is ignored.
- On `ack` while in ACTIVE: the next cycle gives `rsp_valid` = 1, `rsp_rdata` = `we ? 0 : data_s2m` (sampled), `rsp_err` = 0.
- On `err` while in ACTIVE:
  - the next cycle gives `rsp_valid` = 1, `rsp_err` = 1;
  - `cyc` and `stb` drop on the same edge;
  - state goes to ABORT with `pending = count − 1`, plus 1 if `stb` was high;
  - `ack` and `err` at the same time are treated as `err`.
- Timeout timer:
  - 16-bit counter clears on any `ack|err`, on issue, or when `count == 0`; otherwise it increments while in ACTIVE;
  - reaching `TIMEOUT` drops `cyc`/`stb` and enters ABORT with `pending = count + stb`;
  - no response is emitted for that cycle itself.
- ABORT:
  - emits one `rsp_valid` = 1, `rsp_err` = 1 per cycle until `pending` reaches 0, then goes to IDLE;
  - `ack`/`err` are ignored in this state.
- ACTIVE→IDLE when `count_next == 0`, `stb_next == 0`, and no request is accepted. `cyc` falls on that edge.
- Responses always come back in request order; every accepted request yields exactly one response.

## Timing
- Reset (async, `rst` = 1):
  - all outputs 0 (`cyc`, `stb`, `we`, `addr`, `data_m2s`, `sel`, `rsp_*`);
  - `req_ready` = 1 after reset is released;
  - state IDLE, `count` = 0, timer = 0.
- A reset during ACTIVE or ABORT drops `cyc` immediately and emits no responses for in-flight transfers.
- Latency:
  - accept edge → `stb` high: 1 cycle;
  - `ack` → `rsp_valid`: 1 cycle;
  - zero-wait read, accept to response: 3 edges.
- Throughput: one transfer per cycle with `stall` = 0, as long as responses keep `count < MAX_OUTSTANDING`.
- `req_ready` is combinational from `req_we`, `stall` and state; it has no dependence on `req_valid`.
- `rsp_valid` is never high for two responses in the same cycle (at most one `ack`/`err` per cycle by protocol).

## Test plan
- Single read to 0x1000_0004, slave acks 1 cycle after `stb` with `data_s2m` = 0xDEADBEEF → exactly one `rsp_valid` with `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0; `cyc` is low 1 cycle after the ack.
- Burst of 6 writes, `MAX_OUTSTANDING` = 4, slave never stalls and acks with 3-cycle latency → `req_ready` falls once `count` = 4; 6 responses in order, all `rsp_err` = 0; `cyc` is continuous through the burst.
- `stall` held high for 5 cycles on the 2nd read → `stb`/`addr` stable for those 5 cycles, `count` unchanged, no issue until `stall` = 0; responses arrive in order.
- Read followed immediately by a write → `req_ready` stays 0 for the write until the read is acked; `we` rises only after `count` = 0.
- 3 reads outstanding, `err` on the first → `rsp_err` = 1 response, `cyc` drops next edge, then 2 more error responses on consecutive cycles, then IDLE.
- `TIMEOUT` = 8, 2 reads issued, slave silent → `cyc` drops 8 cycles after the last issue; 2 error responses follow. `rst` pulsed mid-burst → all outputs 0 asynchronously.
